// File: rtl/pwm_ctrl_mc.sv
// Multi-channel PWM generator configured by framed bytes from a standard
// (non-show-ahead) 8-bit read FIFO. Frame = header (4'hA, channel) followed
// by period then duty, each CW bits MSB-first. New values are double-buffered
// and applied only at the addressed channel's period boundary.
// Optional feature macro: PWM_FRAME_TIMEOUT_EN (aborts a stalled frame after
// TIMEOUT idle cycles in PAYLOAD).
module pwm_ctrl_mc #(
  parameter int NCH     = 4,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [7:0]     rd_data,
  input  logic           rd_empty,
  output logic           rd_req,
  output logic [NCH-1:0] pwm_out,
  output logic           frame_err,
  output logic [NCH-1:0] upd_done
);

  localparam int NB     = CW / 8;
  localparam int NBYTES = 2 * NB;
  localparam int BCW    = $clog2(NBYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  if (NCH < 1 || NCH > 16 || CW < 8 || CW > 32 || (CW % 8) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("pwm_ctrl_mc: parameter out of range");
  end

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_COMMIT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        ch_q, ch_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [2*CW-1:0]   stage_q, stage_d;
  logic              valid_q;      // a byte requested last cycle is on rd_data now
  logic              run_q;        // keeps rd_req low while in reset and its first cycle
  logic              frame_err_q, frame_err_d;
  logic              fetch_en;
  logic              commit_en;
  logic              hdr_ok;
  logic              last_byte;
  logic              ch_ok;
  logic              timeout_hit;

  assign hdr_ok    = (rd_data[7:4] == 4'hA);
  assign last_byte = valid_q && (byte_cnt_q == LAST_BYTE);
  assign ch_ok     = ({1'b0, ch_q} < 5'(NCH));
  assign rd_req    = fetch_en && !rd_empty;
  assign frame_err = frame_err_q;

`ifdef PWM_FRAME_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;

  // Idle counter: runs on empty cycles mid-frame, cleared by any captured byte.
  always_comb begin
    idle_d = idle_q;
    if (state_q != S_PAYLOAD || valid_q) idle_d = '0;
    else if (rd_empty)                   idle_d = idle_q + 1'b1;
  end

  assign timeout_hit = (state_q == S_PAYLOAD) && !valid_q && rd_empty &&
                       (idle_q == IW'(TIMEOUT - 1));

  // Idle counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Parser state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_HDR;
    else          state_q <= state_d;
  end

  // Parser next-state logic.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR:     if (valid_q && hdr_ok) state_d = S_PAYLOAD;
      S_PAYLOAD: if (last_byte)         state_d = S_COMMIT;
                 else if (timeout_hit)  state_d = S_HDR;
      S_COMMIT:                         state_d = S_HDR;
      default:                          state_d = S_HDR;
    endcase
  end

  // Parser outputs: FIFO fetch enable, error pulse request, commit strobe.
  always_comb begin
    fetch_en    = 1'b0;
    frame_err_d = 1'b0;
    commit_en   = 1'b0;
    unique case (state_q)
      S_HDR: begin
        fetch_en    = run_q;
        frame_err_d = valid_q && !hdr_ok;
      end
      S_PAYLOAD: begin
        // Stop fetching once the final payload byte is already in flight.
        fetch_en    = !last_byte;
        frame_err_d = timeout_hit;
      end
      S_COMMIT: begin
        commit_en   = ch_ok;
        frame_err_d = !ch_ok;
      end
      default: ;
    endcase
  end

  // Datapath next values: channel latch, byte counter, staging shift register.
  always_comb begin
    ch_d       = ch_q;
    byte_cnt_d = byte_cnt_q;
    stage_d    = stage_q;
    if (state_q == S_HDR && valid_q && hdr_ok) begin
      ch_d       = rd_data[3:0];
      byte_cnt_d = '0;
    end
    if (state_q == S_PAYLOAD && valid_q) begin
      stage_d    = {stage_q[2*CW-9:0], rd_data};
      byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  // Datapath registers and FIFO read tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_q        <= '0;
      byte_cnt_q  <= '0;
      stage_q     <= '0;
      valid_q     <= 1'b0;
      run_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      byte_cnt_q  <= byte_cnt_d;
      stage_q     <= stage_d;
      valid_q     <= rd_req;
      run_q       <= 1'b1;
      frame_err_q <= frame_err_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] per_act_q, duty_act_q, per_sh_q, duty_sh_q, cnt_q;
    logic          pend_q, pwm_q, upd_q;
    logic          commit_here, boundary, apply;

    assign commit_here = commit_en && (ch_q == 4'(i));
    assign boundary    = (per_act_q == '0) || (cnt_q == per_act_q - 1'b1);
    assign apply       = boundary && pend_q;
    assign pwm_out[i]  = pwm_q;
    assign upd_done[i] = upd_q;

    // Shadow registers: latest commit wins; a same-cycle commit keeps pending set.
    // NOTE: shadow registers are reset because a stale pending shadow must
    // never apply after reset; storage with no such hazard can skip reset.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        per_sh_q  <= '0;
        duty_sh_q <= '0;
        pend_q    <= 1'b0;
      end else if (commit_here) begin
        per_sh_q  <= stage_q[2*CW-1:CW];
        duty_sh_q <= stage_q[CW-1:0];
        pend_q    <= 1'b1;
      end else if (apply) begin
        pend_q    <= 1'b0;
      end
    end

    // Active values, period counter and registered PWM output.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        per_act_q  <= '0;
        duty_act_q <= '0;
        cnt_q      <= '0;
        pwm_q      <= 1'b0;
        upd_q      <= 1'b0;
      end else begin
        pwm_q <= (per_act_q != '0) && (cnt_q < duty_act_q);
        upd_q <= apply;
        if (apply) begin
          per_act_q  <= per_sh_q;
          duty_act_q <= duty_sh_q;
          cnt_q      <= '0;
        end else if (boundary) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule
